// File: rtl/pong_ball_mover.sv
// Ball animation engine: erase / step-with-bounce / redraw of a 4x4 ball on each accepted tick.
// Pixel stream and hit pulses are registered. A move occupies 33 busy cycles, and ticks arriving while busy are dropped.
module pong_ball_mover #(
  parameter int          SCREEN_W    = 160,
  parameter int          SCREEN_H    = 120,
  parameter int          X_INIT      = 80,
  parameter int          Y_INIT      = 60,
  parameter logic [2:0]  BALL_COLOUR = 3'b111,
  parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  input  logic       tick,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       hit_left,
  output logic       hit_right
);

  typedef enum logic [2:0] {INIT_DRAW, IDLE, ERASE, UPDATE, DRAW} state_t;

  localparam logic [7:0] X_MAX = 8'(SCREEN_W - 4);
  localparam logic [6:0] Y_MAX = 7'(SCREEN_H - 4);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [7:0] bx, bx_n;
  logic [6:0] by, by_n;
  logic       dx, dx_n, dy, dy_n;
  logic       hl_pend, hl_pend_n, hr_pend, hr_pend_n;

  logic [7:0] x_d;
  logic [6:0] y_d;
  logic [2:0] colour_d;
  logic       plot_d, busy_d, hit_left_d, hit_right_d;

  logic [7:0] pix_x;
  logic [6:0] pix_y;

  // cnt names the pixel being emitted on this edge, so registered outputs show it the next cycle.
  assign pix_x = bx + {6'd0, cnt[1:0]};
  assign pix_y = by + {5'd0, cnt[3:2]};

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bx_n        = bx;
    by_n        = by;
    dx_n        = dx;
    dy_n        = dy;
    hl_pend_n   = hl_pend;
    hr_pend_n   = hr_pend;
    x_d         = 8'd0;
    y_d         = 7'd0;
    colour_d    = 3'd0;
    plot_d      = 1'b0;
    busy_d      = 1'b0;
    hit_left_d  = 1'b0;
    hit_right_d = 1'b0;

    case (state)
      INIT_DRAW: begin
        plot_d   = 1'b1;
        busy_d   = 1'b1;
        x_d      = pix_x;
        y_d      = pix_y;
        colour_d = BALL_COLOUR;
        cnt_n    = cnt + 4'd1;
        if (cnt == 4'd15) state_n = IDLE;
      end
      IDLE: begin
        if (tick && enable) begin
          // First erase pixel leaves on the accepting edge; ERASE continues from pixel 1.
          state_n  = ERASE;
          cnt_n    = 4'd1;
          plot_d   = 1'b1;
          busy_d   = 1'b1;
          x_d      = bx;
          y_d      = by;
          colour_d = BG_COLOUR;
        end
      end
      ERASE: begin
        plot_d   = 1'b1;
        busy_d   = 1'b1;
        x_d      = pix_x;
        y_d      = pix_y;
        colour_d = BG_COLOUR;
        cnt_n    = cnt + 4'd1;
        if (cnt == 4'd15) state_n = UPDATE;
      end
      UPDATE: begin
        busy_d  = 1'b1;
        state_n = DRAW;
        cnt_n   = 4'd0;
        if (dx && bx == X_MAX) begin
          dx_n      = 1'b0;
          bx_n      = bx - 8'd1;
          hr_pend_n = 1'b1;
        end else if (!dx && bx == 8'd0) begin
          dx_n      = 1'b1;
          bx_n      = 8'd1;
          hl_pend_n = 1'b1;
        end else begin
          bx_n = dx ? bx + 8'd1 : bx - 8'd1;
        end
        if (dy && by == Y_MAX) begin
          dy_n = 1'b0;
          by_n = by - 7'd1;
        end else if (!dy && by == 7'd0) begin
          dy_n = 1'b1;
          by_n = 7'd1;
        end else begin
          by_n = dy ? by + 7'd1 : by - 7'd1;
        end
      end
      DRAW: begin
        plot_d   = 1'b1;
        busy_d   = 1'b1;
        x_d      = pix_x;
        y_d      = pix_y;
        colour_d = BALL_COLOUR;
        cnt_n    = cnt + 4'd1;
        if (cnt == 4'd0) begin
          // Hit pulses are held back so they line up with the first redrawn pixel.
          hit_left_d  = hl_pend;
          hit_right_d = hr_pend;
          hl_pend_n   = 1'b0;
          hr_pend_n   = 1'b0;
        end
        if (cnt == 4'd15) state_n = IDLE;
      end
      default: state_n = INIT_DRAW;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= INIT_DRAW;
      cnt       <= 4'd0;
      bx        <= 8'(X_INIT);
      by        <= 7'(Y_INIT);
      dx        <= 1'b1;
      dy        <= 1'b1;
      hl_pend   <= 1'b0;
      hr_pend   <= 1'b0;
      x_out     <= 8'd0;
      y_out     <= 7'd0;
      colour    <= 3'd0;
      plot      <= 1'b0;
      busy      <= 1'b0;
      hit_left  <= 1'b0;
      hit_right <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bx        <= bx_n;
      by        <= by_n;
      dx        <= dx_n;
      dy        <= dy_n;
      hl_pend   <= hl_pend_n;
      hr_pend   <= hr_pend_n;
      x_out     <= x_d;
      y_out     <= y_d;
      colour    <= colour_d;
      plot      <= plot_d;
      busy      <= busy_d;
      hit_left  <= hit_left_d;
      hit_right <= hit_right_d;
    end
  end

endmodule

// File: tb/tb_pong_ball_mover.sv
// Randomised bench for pong_ball_mover: a move-level ball model feeds a pixel scoreboard checked by a monitor.
module tb_pong_ball_mover;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       plot, busy, hit_left, hit_right;

  pong_ball_mover #(
    .SCREEN_W(160), .SCREEN_H(120), .X_INIT(80), .Y_INIT(60),
    .BALL_COLOUR(3'b111), .BG_COLOUR(3'b000)
  ) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .tick(tick),
    .x_out(x_out), .y_out(y_out), .colour(colour), .plot(plot),
    .busy(busy), .hit_left(hit_left), .hit_right(hit_right)
  );

  always #5 clock = ~clock;

  typedef struct {
    int x;
    int y;
    int c;
    bit hl;
    bit hr;
  } pix_t;

  pix_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Model: ball position/direction plus remaining busy cycles after the last edge.
  int   m_bx, m_by;
  bit   m_dx, m_dy;
  int   rem = 0;
  bit   in_move = 0;
  bit   init_pending = 1;
  bit   started = 0;
  bit   exp_busy = 0, exp_plot = 0, exp_zero = 1;
  int   exp_hl_cnt = 0, exp_hr_cnt = 0, obs_hl = 0, obs_hr = 0;

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_sprite(input int x0, input int y0, input int c, input bit hl, input bit hr);
    pix_t p;
    for (int i = 0; i < 16; i++) begin
      p.x  = x0 + i % 4;
      p.y  = y0 + i / 4;
      p.c  = c;
      p.hl = (i == 0) && hl;
      p.hr = (i == 0) && hr;
      exp_q.push_back(p);
    end
  endtask

  task automatic step_axis(inout int p, inout bit d, input int maxv, output bit lo, output bit hi);
    lo = 0;
    hi = 0;
    if (d && p == maxv) begin
      d = 0; p = p - 1; hi = 1;
    end else if (!d && p == 0) begin
      d = 1; p = 1; lo = 1;
    end else begin
      p = d ? p + 1 : p - 1;
    end
  endtask

  task automatic model_edge(input bit r, input bit t, input bit e);
    bit hl, hr, ylo, yhi;
    started = 1;
    if (!r) begin
      rem = 0; in_move = 0; init_pending = 1;
      m_bx = 80; m_by = 60; m_dx = 1; m_dy = 1;
      exp_q.delete();
      exp_zero = 1; exp_busy = 0; exp_plot = 0;
      return;
    end
    exp_zero = 0;
    if (init_pending) begin
      init_pending = 0;
      rem = 16;
      in_move = 0;
      push_sprite(m_bx, m_by, 7, 0, 0);
    end else begin
      if (rem > 0) rem--;
      if (rem == 0 && t && e) begin
        push_sprite(m_bx, m_by, 0, 0, 0);
        step_axis(m_bx, m_dx, 156, hl, hr);
        step_axis(m_by, m_dy, 116, ylo, yhi);
        if (hl) exp_hl_cnt++;
        if (hr) exp_hr_cnt++;
        push_sprite(m_bx, m_by, 7, hl, hr);
        rem = 33;
        in_move = 1;
      end
    end
    exp_busy = (rem > 0);
    exp_plot = (rem > 0) && !(in_move && rem == 17);
  endtask

  task automatic cycle(input bit r, input bit t, input bit e);
    @(posedge clock);
    model_edge(resetn, tick, enable);
    #1;
    resetn = r;
    tick   = t;
    enable = e;
  endtask

  // Monitor: per-cycle busy/plot, reset-state outputs, and pixel scoreboard pops.
  initial begin
    pix_t p;
    forever begin
      @(negedge clock);
      if (started) begin
        chk("busy", int'(busy), int'(exp_busy));
        chk("plot", int'(plot), int'(exp_plot));
        if (hit_left)  obs_hl++;
        if (hit_right) obs_hr++;
        if (exp_zero) begin
          chk("reset_outputs", int'({x_out, y_out, colour, hit_left, hit_right}), 0);
        end
        if (plot) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pixel", 1, 0);
          end else begin
            p = exp_q.pop_front();
            chk("x_out", int'(x_out), p.x);
            chk("y_out", int'(y_out), p.y);
            chk("colour", int'(colour), p.c);
            chk("hit_left", int'(hit_left), int'(p.hl));
            chk("hit_right", int'(hit_right), int'(p.hr));
          end
        end else begin
          chk("hit_idle", int'({hit_left, hit_right}), 0);
        end
      end
    end
  end

  initial begin
    repeat (3) cycle(0, 0, 0);
    repeat (25) cycle(1, 0, 1);
    // Single move, a re-tick mid-sequence, and a tick with enable low.
    cycle(1, 1, 1);
    repeat (4) cycle(1, 0, 1);
    cycle(1, 1, 1);
    repeat (40) cycle(1, 0, 1);
    cycle(1, 1, 0);
    repeat (40) cycle(1, 0, 1);
    // Reset during the seventh erase cycle.
    for (int i = 0; i < 200; i++) begin
      cycle(1, 1, 1);
      if (in_move && rem == 27) break;
    end
    resetn = 0;
    cycle(0, 0, 1);
    cycle(1, 0, 1);
    for (int i = 0; i < 15000; i++) begin
      cycle(1, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0));
    end
    repeat (40) cycle(1, 0, 1);
    @(negedge clock);
    #1;
    chk("queue_drain", exp_q.size(), 0);
    chk("hit_left_count", obs_hl, exp_hl_cnt);
    chk("hit_right_count", obs_hr, exp_hr_cnt);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
